in_port_ctrl: RTL and testbench

Input-side peripheral for the TramelBlaze: the read counterpart to the write-decoded output registers. It synchronizes the switch inputs and counts button events. It raises and holds INTERRUPT until acknowledged, and returns switch, status and event-count data on IN_PORT according to PORT_ID. Read strobes clear the status and count registers.

---
 rtl/in_port_ctrl.sv | 116 +++++++++++
 tb/tb_in_port_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/in_port_ctrl.sv
// in_port_ctrl: input-side peripheral for the TramelBlaze processor.
// Synchronizes the switch inputs and counts button events. Raises a held
// interrupt on each event until the processor acknowledges it. Returns switch,
// status or count data on in_port according to port_id. Reads of the status
// and count ports clear the corresponding registers.
// Optional macro IN_PORT_CTRL_SYNC2_EN selects a two-flop switch synchronizer;
// without it a single register stage samples sw (sw must then be synchronous).
module in_port_ctrl #(
    parameter int SW_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] sw,
    input  logic            evt,
    input  logic [15:0]     port_id,
    input  logic            read_strobe,
    input  logic            int_ack,
    output logic [15:0]     in_port,
    output logic            interrupt
);

    localparam logic [15:0] PORT_SW     = 16'h0000;
    localparam logic [15:0] PORT_STATUS = 16'h0001;
    localparam logic [15:0] PORT_COUNT  = 16'h0002;
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    logic [SW_W-1:0] sw_q;
    logic [15:0]     cnt;
    logic            ovf;
    logic            pend;
    logic [15:0]     sw_ext;
    logic            rd_status;
    logic            rd_count;
    logic            cnt_full;

    assign rd_status = read_strobe && (port_id == PORT_STATUS);
    assign rd_count  = read_strobe && (port_id == PORT_COUNT);
    assign cnt_full  = (cnt == CNT_MAX);

`ifdef IN_PORT_CTRL_SYNC2_EN
    logic [SW_W-1:0] sw_meta;

    // Two-flop synchronizer: sw is asynchronous to clk, so a metastable first stage is tolerated
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_q    <= '0;
        end else begin
            sw_meta <= sw;
            sw_q    <= sw_meta;
        end
    end
`else
    // Single sampling stage for switch buses that are already clk-synchronous
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_q <= '0;
        end else begin
            sw_q <= sw;
        end
    end
`endif

    // Event counter: saturates at all-ones; a count read clears it without losing a coincident event
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (rd_count) begin
            cnt <= evt ? 16'd1 : 16'd0;
        end else if (evt && !cnt_full) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Overflow flag: a saturating event wins over a status read in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (evt && cnt_full) begin
            ovf <= 1'b1;
        end else if (rd_status) begin
            ovf <= 1'b0;
        end
    end

    // Interrupt pending: events set it (set wins over ack), only int_ack clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend <= 1'b0;
        end else if (evt) begin
            pend <= 1'b1;
        end else if (int_ack) begin
            pend <= 1'b0;
        end
    end

    assign interrupt = pend;

    // Zero-extend the switch snapshot to the 16-bit data bus
    always_comb begin
        sw_ext            = '0;
        sw_ext[SW_W-1:0]  = sw_q;
    end

    // Read mux: combinational so the processor sees data in the same cycle as port_id
    always_comb begin
        in_port = 16'h0000;
        case (port_id)
            PORT_SW:     in_port = sw_ext;
            PORT_STATUS: in_port = {cnt[7:0], 6'b000000, ovf, pend};
            PORT_COUNT:  in_port = cnt;
            default:     in_port = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_in_port_ctrl.sv
// tb_in_port_ctrl: directed self-checking bench for in_port_ctrl.
// A second instance with SW_W=4 covers the narrow-switch readback.
module tb_in_port_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] sw;
    logic [3:0]  sw4;
    logic        evt;
    logic [15:0] port_id;
    logic        read_strobe;
    logic        int_ack;
    logic [15:0] in_port;
    logic [15:0] in_port4;
    logic        interrupt;
    logic        interrupt4;

    int compared;
    int mismatched;

    logic [15:0] rd;

    in_port_ctrl #(.SW_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw),
        .evt         (evt),
        .port_id     (port_id),
        .read_strobe (read_strobe),
        .int_ack     (int_ack),
        .in_port     (in_port),
        .interrupt   (interrupt)
    );

    in_port_ctrl #(.SW_W(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .sw          (sw4),
        .evt         (evt),
        .port_id     (port_id),
        .read_strobe (read_strobe),
        .int_ack     (int_ack),
        .in_port     (in_port4),
        .interrupt   (interrupt4)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every comparison and report any mismatch
    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseEvt();
        evt = 1'b1;
        tick();
        evt = 1'b0;
    endtask

    task automatic ackInt();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    // Look at a port without a read strobe
    task automatic peek(input logic [15:0] addr, output logic [15:0] val);
        port_id = addr;
        #1;
        val = in_port;
    endtask

    // Processor IN instruction: value seen before the clearing edge
    task automatic readPort(input logic [15:0] addr, output logic [15:0] val);
        port_id     = addr;
        read_strobe = 1'b1;
        #1;
        val = in_port;
        tick();
        read_strobe = 1'b0;
        port_id     = 16'h0000;
    endtask

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b0;
        sw          = 16'h0000;
        sw4         = 4'hF;
        evt         = 1'b0;
        port_id     = 16'h0000;
        read_strobe = 1'b0;
        int_ack     = 1'b0;

        // Reset state while reset is held
        tick();
        tick();
        checkOutput("rst_interrupt", {15'd0, interrupt}, 16'h0000);
        peek(16'h0000, rd); checkOutput("rst_p0", rd, 16'h0000);
        peek(16'h0001, rd); checkOutput("rst_p1", rd, 16'h0000);
        peek(16'h0002, rd); checkOutput("rst_p2", rd, 16'h0000);
        peek(16'h0007, rd); checkOutput("rst_p7", rd, 16'h0000);
        reset = 1'b1;
        tick();

        // Build cnt=5, pend=1, then reset mid-run with events during reset
        for (int i = 0; i < 5; i++) pulseEvt();
        peek(16'h0002, rd); checkOutput("pre_rst_cnt", rd, 16'h0005);
        checkOutput("pre_rst_int", {15'd0, interrupt}, 16'h0001);
        reset = 1'b0;
        #1;
        checkOutput("async_rst_int", {15'd0, interrupt}, 16'h0000);
        evt = 1'b1;
        tick();
        tick();
        evt = 1'b0;
        reset = 1'b1;
        tick();
        readPort(16'h0000, rd); checkOutput("post_rst_p0", rd, 16'h0000);
        readPort(16'h0001, rd); checkOutput("post_rst_p1", rd, 16'h0000);
        readPort(16'h0002, rd); checkOutput("post_rst_p2", rd, 16'h0000);
        readPort(16'h0007, rd); checkOutput("post_rst_p7", rd, 16'h0000);
        checkOutput("post_rst_int", {15'd0, interrupt}, 16'h0000);

        // Three events 10 cycles apart, coalesced into one interrupt
        pulseEvt();
        checkOutput("int_after_evt1", {15'd0, interrupt}, 16'h0001);
        for (int i = 0; i < 9; i++) tick();
        pulseEvt();
        for (int i = 0; i < 9; i++) tick();
        pulseEvt();
        checkOutput("int_held", {15'd0, interrupt}, 16'h0001);
        readPort(16'h0001, rd); checkOutput("status_3evt", rd, 16'h0301);
        readPort(16'h0002, rd); checkOutput("count_3evt", rd, 16'h0003);
        readPort(16'h0002, rd); checkOutput("count_cleared", rd, 16'h0000);
        readPort(16'h0001, rd); checkOutput("pend_survives_read", rd, 16'h0001);
        readPort(16'h0005, rd); checkOutput("other_port_read", rd, 16'h0000);
        checkOutput("int_after_reads", {15'd0, interrupt}, 16'h0001);
        ackInt();
        checkOutput("int_after_ack", {15'd0, interrupt}, 16'h0000);

        // evt and int_ack together: set wins
        pulseEvt();
        evt     = 1'b1;
        int_ack = 1'b1;
        tick();
        evt     = 1'b0;
        int_ack = 1'b0;
        checkOutput("evt_ack_same", {15'd0, interrupt}, 16'h0001);
        readPort(16'h0002, rd); checkOutput("cnt_evt_ack", rd, 16'h0002);
        ackInt();
        checkOutput("ack_alone", {15'd0, interrupt}, 16'h0000);

        // Count read with a coincident event: pre-clear value seen, event kept
        for (int i = 0; i < 4; i++) pulseEvt();
        evt = 1'b1;
        readPort(16'h0002, rd);
        evt = 1'b0;
        checkOutput("read_with_evt", rd, 16'h0004);
        peek(16'h0002, rd); checkOutput("cnt_after_rd_evt", rd, 16'h0001);
        readPort(16'h0002, rd);
        ackInt();

        // Saturation: 65535 events, then one more
        evt = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        evt = 1'b0;
        peek(16'h0002, rd); checkOutput("cnt_full", rd, 16'hFFFF);
        peek(16'h0001, rd); checkOutput("status_full_no_ovf", rd, 16'hFF01);
        pulseEvt();
        peek(16'h0002, rd); checkOutput("cnt_saturated", rd, 16'hFFFF);
        readPort(16'h0001, rd); checkOutput("status_ovf_set", rd, 16'hFF03);
        readPort(16'h0001, rd); checkOutput("status_ovf_clear", rd, 16'hFF01);
        evt = 1'b1;
        readPort(16'h0001, rd);
        evt = 1'b0;
        checkOutput("status_rd_sat_evt", rd, 16'hFF01);
        peek(16'h0001, rd); checkOutput("ovf_set_wins", rd, 16'hFF03);

        // Switch latency: change between edges
        port_id = 16'h0000;
        sw = 16'hA5C3;
        tick();
        peek(16'h0000, rd);
`ifdef IN_PORT_CTRL_SYNC2_EN
        checkOutput("sw_edge1", rd, 16'h0000);
`else
        checkOutput("sw_edge1", rd, 16'hA5C3);
`endif
        tick();
        peek(16'h0000, rd); checkOutput("sw_edge2", rd, 16'hA5C3);

        // Narrow switch bus is zero-extended
        port_id = 16'h0000;
        #1;
        checkOutput("sw4_zero_ext", in_port4, 16'h000F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
